// File: rtl/ds_addr_gen_pkg.sv
// ds_addr_gen_pkg: shared state encoding, kind constants and default bus width
// for the 2x2 down-sampling address generator.
package ds_addr_gen_pkg;
    localparam int AW_DEF = 18;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S0   = 3'd1,
        S1   = 3'd2,
        S2   = 3'd3,
        S3   = 3'd4,
        DST  = 3'd5,
        FIN  = 3'd6
    } state_t;
    localparam logic KIND_SRC = 1'b0;
    localparam logic KIND_DST = 1'b1;
endpackage

// File: rtl/ds_pix_counter.sv
// ds_pix_counter: output-image row/col counter for the down-sampler.
// Ports: clk (state on falling edge), rst (async active-low clear),
//        clr (sync clear at frame start), advance (step one output pixel),
//        row_nxt/col_nxt (value the counter takes at the coming edge),
//        last (current position is the final output pixel).
module ds_pix_counter #(
    parameter int COLS = 128,
    parameter int ROWS = 128,
    parameter int CW   = 7,
    parameter int RW   = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          advance,
    output logic [RW-1:0] row_nxt,
    output logic [CW-1:0] col_nxt,
    output logic          last
);
    localparam logic [CW-1:0] CMAX = CW'(COLS - 1);
    localparam logic [RW-1:0] RMAX = RW'(ROWS - 1);
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          wrap;
    // Next values are exported so the owner can register outputs that
    // already reflect the post-edge position.
    always_comb begin
        wrap    = advance && (col == CMAX);
        col_nxt = clr ? '0 : (advance ? ((col == CMAX) ? '0 : col + 1'b1) : col);
        row_nxt = clr ? '0 : (wrap ? ((row == RMAX) ? '0 : row + 1'b1) : row);
        last    = (row == RMAX) && (col == CMAX);
    end
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else begin
            row <= row_nxt;
            col <= col_nxt;
        end
    end
endmodule

// File: rtl/ds_addr_gen.sv
// ds_addr_gen: 2x2 down-sampling address sequencer. Per output pixel it emits
// four source read addresses then one destination write address over a
// valid/ready handshake, and pulses done at frame end.
// Ports: clk (state on falling edge), rst (async active-low), start (frame
//        launch, sampled in IDLE), ready (consumer accepts addr),
//        addr/valid/kind (address stream, kind 1 = destination),
//        busy (not IDLE), done (one-cycle frame-end pulse).
module ds_addr_gen
    import ds_addr_gen_pkg::*;
#(
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int DST_BASE = 65536,
    parameter int AW       = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ready,
    output logic [AW-1:0] addr,
    output logic          valid,
    output logic          kind,
    output logic          busy,
    output logic          done
);
    localparam int COLS = IMG_W / 2;
    localparam int ROWS = IMG_H / 2;
    localparam int CW   = $clog2(COLS > 1 ? COLS : 2);
    localparam int RW   = $clog2(ROWS > 1 ? ROWS : 2);
    state_t        state, nxt;
    logic          xfer, last;
    logic [RW-1:0] row_nxt;
    logic [CW-1:0] col_nxt;
    function automatic logic [AW-1:0] addr_of(state_t s, logic [RW-1:0] r, logic [CW-1:0] c);
        logic [AW-1:0] ro, co, b;
        ro = AW'(r);
        co = AW'(c);
        b  = (ro << 1) * AW'(IMG_W) + (co << 1);
        case (s)
            S0:      return b;
            S1:      return b + 1'b1;
            S2:      return b + AW'(IMG_W);
            S3:      return b + AW'(IMG_W) + 1'b1;
            DST:     return AW'(DST_BASE) + ro * AW'(COLS) + co;
            default: return '0;
        endcase
    endfunction
    ds_pix_counter #(.COLS(COLS), .ROWS(ROWS), .CW(CW), .RW(RW)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == IDLE && start),
        .advance (state == DST && xfer),
        .row_nxt (row_nxt),
        .col_nxt (col_nxt),
        .last    (last)
    );
    always_comb begin
        xfer = valid & ready;
        case (state)
            IDLE:    nxt = start ? S0 : IDLE;
            S0:      nxt = xfer ? S1 : S0;
            S1:      nxt = xfer ? S2 : S1;
            S2:      nxt = xfer ? S3 : S2;
            S3:      nxt = xfer ? DST : S3;
            DST:     nxt = xfer ? (last ? FIN : S0) : DST;
            default: nxt = IDLE;
        endcase
    end
    // Outputs are registered from the next state and next counter values so
    // they change on the same edge as the state they describe.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            addr  <= '0;
            valid <= 1'b0;
            kind  <= KIND_SRC;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= nxt;
            addr  <= addr_of(nxt, row_nxt, col_nxt);
            valid <= nxt inside {S0, S1, S2, S3, DST};
            kind  <= (nxt == DST) ? KIND_DST : KIND_SRC;
            busy  <= nxt != IDLE;
            done  <= nxt == FIN;
        end
    end
endmodule

// File: tb/tb_ds_addr_gen.sv
// tb_ds_addr_gen: self-checking bench for ds_addr_gen (4x4 and 256x256 frames).
module tb_ds_addr_gen;
    typedef struct {
        logic [17:0] addr;
        logic        kind;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_start = 1'b0, s_ready = 1'b0;
    logic [17:0] s_addr;
    logic        s_valid, s_kind, s_busy, s_done;
    logic        b_start = 1'b0, b_ready = 1'b0;
    logic [17:0] b_addr;
    logic        b_valid, b_kind, b_busy, b_done;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[20];
    vec_t q[$];

    always #5 clk = ~clk;

    ds_addr_gen #(.IMG_W(4), .IMG_H(4), .DST_BASE(64), .AW(18)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .ready(s_ready),
        .addr(s_addr), .valid(s_valid), .kind(s_kind), .busy(s_busy), .done(s_done)
    );

    ds_addr_gen dut_b (
        .clk(clk), .rst(rst), .start(b_start), .ready(b_ready),
        .addr(b_addr), .valid(b_valid), .kind(b_kind), .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Launches one 4x4 frame with the expected stream queued, then walks it.
    // stall: ready low for 3 cycles while pixel 1 sits in S2 (addr 6).
    // restart_at: cycle at which a stray start pulse is applied mid-frame.
    // abort_at: cycle at which rst drops (expected during DST of pixel 1).
    task automatic run_frame(input bit stall, input int restart_at, input int abort_at,
                             input bit hold_start, output int done_at);
        vec_t e;
        q.delete();
        foreach (tbl[k]) q.push_back(tbl[k]);
        @(posedge clk);
        s_start = 1'b1;
        s_ready = 1'b1;
        done_at = 0;
        for (int i = 1; i <= 60 && done_at == 0; i++) begin
            @(posedge clk);
            s_start = hold_start || (i == restart_at);
            s_ready = !(stall && i >= 8 && i <= 10);
            if (i == abort_at) begin
                chk("abort_pre_kind", 32'(s_kind), 32'd1);
                chk("abort_pre_addr", 32'(s_addr), 32'd65);
                rst = 1'b0;
                #1;
                chk("abort_addr", 32'(s_addr), 32'd0);
                chk("abort_valid", 32'(s_valid), 32'd0);
                chk("abort_kind", 32'(s_kind), 32'd0);
                chk("abort_busy", 32'(s_busy), 32'd0);
                chk("abort_done", 32'(s_done), 32'd0);
                repeat (3) begin
                    @(posedge clk);
                    chk("abort_no_done", 32'(s_done), 32'd0);
                end
                s_start = 1'b0;
                rst = 1'b1;
                q.delete();
                return;
            end
            if (stall && i >= 8 && i <= 11) begin
                chk("stall_addr", 32'(s_addr), 32'd6);
                chk("stall_valid", 32'(s_valid), 32'd1);
            end
            if (s_done) done_at = i;
            else if (s_valid && s_ready) begin
                if (q.size() == 0) chk("unexpected_xfer", 32'(s_addr), 32'hffffffff);
                else begin
                    e = q.pop_front();
                    chk("xfer_addr", 32'(s_addr), 32'(e.addr));
                    chk("xfer_kind", 32'(s_kind), 32'(e.kind));
                end
            end
        end
        chk("done_seen", 32'(done_at != 0), 32'd1);
        chk("queue_drained", 32'(q.size()), 32'd0);
        @(posedge clk);
        chk("post_done", 32'(s_done), 32'd0);
        chk("post_busy", 32'(s_busy), 32'd0);
        chk("post_valid", 32'(s_valid), 32'd0);
    endtask

    initial begin
        int done_at;
        int n, mx;
        logic [17:0] last5[5];
        tbl = '{
            '{18'd0, 1'b0}, '{18'd1, 1'b0}, '{18'd4, 1'b0}, '{18'd5, 1'b0}, '{18'd64, 1'b1},
            '{18'd2, 1'b0}, '{18'd3, 1'b0}, '{18'd6, 1'b0}, '{18'd7, 1'b0}, '{18'd65, 1'b1},
            '{18'd8, 1'b0}, '{18'd9, 1'b0}, '{18'd12, 1'b0}, '{18'd13, 1'b0}, '{18'd66, 1'b1},
            '{18'd10, 1'b0}, '{18'd11, 1'b0}, '{18'd14, 1'b0}, '{18'd15, 1'b0}, '{18'd67, 1'b1}
        };

        // reset state
        @(posedge clk);
        chk("rst_addr", 32'(s_addr), 32'd0);
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_kind", 32'(s_kind), 32'd0);
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_done", 32'(s_done), 32'd0);
        chk("rst_b_addr", 32'(b_addr), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        chk("idle_busy", 32'(s_busy), 32'd0);

        // plain frame: 20 transfers, done on the 21st cycle
        run_frame(1'b0, 0, 0, 1'b0, done_at);
        chk("plain_done_at", 32'(done_at), 32'd21);

        // ready stalled 3 cycles in S2 of pixel 1
        run_frame(1'b1, 0, 0, 1'b0, done_at);
        chk("stall_done_at", 32'(done_at), 32'd24);

        // start pulsed while busy is ignored
        run_frame(1'b0, 12, 0, 1'b0, done_at);
        chk("restart_done_at", 32'(done_at), 32'd21);

        // reset during DST of pixel 1, then a clean frame from address 0
        run_frame(1'b0, 0, 10, 1'b0, done_at);
        run_frame(1'b0, 0, 0, 1'b0, done_at);
        chk("after_abort_done_at", 32'(done_at), 32'd21);

        // start held high: done, one IDLE cycle, then a new frame at 0
        run_frame(1'b0, 0, 0, 1'b1, done_at);
        chk("hold_done_at", 32'(done_at), 32'd21);
        @(posedge clk);
        chk("hold_relaunch_valid", 32'(s_valid), 32'd1);
        chk("hold_relaunch_addr", 32'(s_addr), 32'd0);
        chk("hold_relaunch_kind", 32'(s_kind), 32'd0);
        s_start = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        rst = 1'b1;

        // full 256x256 frame
        n = 0;
        mx = 0;
        done_at = 0;
        foreach (last5[k]) last5[k] = '0;
        @(posedge clk);
        b_start = 1'b1;
        b_ready = 1'b1;
        for (int i = 1; i <= 82000 && done_at == 0; i++) begin
            @(posedge clk);
            b_start = 1'b0;
            if (b_done) done_at = i;
            else if (b_valid && b_ready) begin
                for (int k = 0; k < 4; k++) last5[k] = last5[k+1];
                last5[4] = b_addr;
                if (int'(b_addr) > mx) mx = int'(b_addr);
                n++;
            end
        end
        chk("big_done_at", 32'(done_at), 32'd81921);
        chk("big_xfers", 32'(n), 32'd81920);
        chk("big_max", 32'(mx), 32'd81919);
        chk("big_tail0", 32'(last5[0]), 32'd65278);
        chk("big_tail1", 32'(last5[1]), 32'd65279);
        chk("big_tail2", 32'(last5[2]), 32'd65534);
        chk("big_tail3", 32'(last5[3]), 32'd65535);
        chk("big_tail4", 32'(last5[4]), 32'd81919);
        @(posedge clk);
        chk("big_post_busy", 32'(b_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
